// File: rtl/codeword_rx_assembler.sv
// codeword_rx_assembler: collects NUM_BYTES UART bytes (LSB first) into one codeword with a valid pulse.
// Optional inter-byte timeout with frame_error pulse is built when CW_RX_TIMEOUT_EN is defined.
module codeword_rx_assembler #(
    parameter int NUM_BYTES      = 9,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             uart_rx_data,
    input  logic                   uart_rx_valid,
    output logic [8*NUM_BYTES-1:0] codeWord,
    output logic                   codeword_valid,
    output logic                   frame_error,
    output logic                   busy,
    output logic [3:0]             byte_cnt
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t                 state;
    logic [8*NUM_BYTES-1:0] sr;
    logic                   done;
    logic                   last;
    logic                   expire;
    assign last = byte_cnt == 4'(NUM_BYTES - 1);
    assign busy = state == COLLECT;
`ifdef CW_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    // a byte on the expiry cycle wins: expire requires no strobe this cycle
    assign expire = state == COLLECT && !uart_rx_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            idle_cnt    <= (state != COLLECT || uart_rx_valid || expire) ? '0 : idle_cnt + 1'b1;
            frame_error <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign frame_error = 1'b0;
`endif
    // codeWord is loaded one edge after the final byte lands in sr; a new lane-0
    // byte written on that same edge does not disturb the word being copied
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sr             <= '0;
            byte_cnt       <= '0;
            done           <= 1'b0;
            codeWord       <= '0;
            codeword_valid <= 1'b0;
        end else begin
            done           <= 1'b0;
            codeword_valid <= done;
            if (done)
                codeWord <= sr;
            if (expire) begin
                state    <= IDLE;
                byte_cnt <= '0;
            end else if (uart_rx_valid) begin
                sr[{byte_cnt, 3'b000} +: 8] <= uart_rx_data;
                byte_cnt <= last ? '0 : byte_cnt + 4'd1;
                state    <= last ? IDLE : COLLECT;
                done     <= last;
            end
        end
    end
endmodule

// File: tb/tb_codeword_rx_assembler.sv
// tb_codeword_rx_assembler: directed checks of framing, back-to-back frames, reset and timeout handling.
module tb_codeword_rx_assembler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic [71:0] codeWord;
    logic        codeword_valid, frame_error, busy;
    logic [3:0]  byte_cnt;
    int checks = 0;
    int fails = 0;
    int nv = 0;
    int ne = 0;
    int nv0, ne0;

    codeword_rx_assembler #(.NUM_BYTES(9), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .codeWord(codeWord), .codeword_valid(codeword_valid), .frame_error(frame_error),
        .busy(busy), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (codeword_valid) nv <= nv + 1;
        if (frame_error) ne <= ne + 1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        pulse_reset();
        chk("reset_cw", codeWord, 72'h0);
        chk("reset_valid", codeword_valid, 1'b0);
        chk("reset_ferr", frame_error, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cnt", byte_cnt, 4'd0);

        // basic frame, 10-cycle spacing
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i == 1) begin
                chk("basic_cnt1", byte_cnt, 4'd1);
                chk("basic_busy1", busy, 1'b1);
            end
            if (i < 9) idle(9);
        end
        chk("basic_cnt_end", byte_cnt, 4'd0);
        chk("basic_valid_early", codeword_valid, 1'b0);
        idle(1);
        chk("basic_valid", codeword_valid, 1'b1);
        chk("basic_cw", codeWord, 72'h090807060504030201);
        idle(1);
        chk("basic_valid_one", codeword_valid, 1'b0);
        chk("basic_cw_hold", codeWord, 72'h090807060504030201);

        // back-to-back frames on consecutive cycles
        idle(2);
        nv0 = nv;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) begin
                chk("b2b_valid1", codeword_valid, 1'b1);
                chk("b2b_cw1", codeWord, 72'h080706050403020100);
                chk("b2b_cnt_at_pulse", byte_cnt, 4'd1);
            end
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(i);
            @(negedge clk);
        end
        uart_rx_valid = 1'b0;
        chk("b2b_cnt_end", byte_cnt, 4'd0);
        chk("b2b_valid_gap", codeword_valid, 1'b0);
        idle(1);
        chk("b2b_valid2", codeword_valid, 1'b1);
        chk("b2b_cw2", codeWord, 72'h11100F0E0D0C0B0A09);
        idle(2);
        chk("b2b_pulses", 72'(nv - nv0), 72'd2);

`ifdef CW_RX_TIMEOUT_EN
        // timeout after 4 bytes
        ne0 = ne;
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
        idle(49);
        chk("to_ferr_early", frame_error, 1'b0);
        chk("to_cnt_hold", byte_cnt, 4'd4);
        idle(1);
        chk("to_ferr", frame_error, 1'b1);
        chk("to_cnt_clr", byte_cnt, 4'd0);
        chk("to_busy_clr", busy, 1'b0);
        chk("to_valid_excl", codeword_valid, 1'b0);
        chk("to_cw_kept", codeWord, 72'h11100F0E0D0C0B0A09);
        idle(1);
        chk("to_ferr_one", frame_error, 1'b0);
        for (int i = 1; i <= 9; i++) send(8'h20 + 8'(i));
        idle(1);
        chk("to_next_valid", codeword_valid, 1'b1);
        chk("to_next_cw", codeWord, 72'h292827262524232221);
        idle(2);
        chk("to_err_pulses", 72'(ne - ne0), 72'd1);

        // byte on the exact expiry cycle wins over the timeout
        ne0 = ne;
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        idle(49);
        send(8'h54);
        chk("race_ferr", frame_error, 1'b0);
        chk("race_cnt", byte_cnt, 4'd5);
        for (int i = 5; i < 9; i++) send(8'h50 + 8'(i));
        idle(1);
        chk("race_valid", codeword_valid, 1'b1);
        chk("race_cw", codeWord, 72'h585756555453525150);
        idle(2);
        chk("race_no_err", 72'(ne - ne0), 72'd0);
`else
        // no timeout: partial frame waits across a long idle gap
        ne0 = ne;
        for (int i = 1; i <= 3; i++) send(8'h30 + 8'(i));
        idle(2000);
        chk("nto_busy", busy, 1'b1);
        chk("nto_cnt", byte_cnt, 4'd3);
        for (int i = 4; i <= 9; i++) send(8'h30 + 8'(i));
        idle(1);
        chk("nto_valid", codeword_valid, 1'b1);
        chk("nto_cw", codeWord, 72'h393837363534333231);
        idle(2);
        chk("nto_no_err", 72'(ne - ne0), 72'd0);
`endif

        // mid-frame reset discards partial frame silently
        nv0 = nv;
        ne0 = ne;
        for (int i = 0; i < 6; i++) send(8'h60 + 8'(i));
        pulse_reset();
        chk("mr_cw", codeWord, 72'h0);
        chk("mr_cnt", byte_cnt, 4'd0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_valid", codeword_valid, 1'b0);
        chk("mr_ferr", frame_error, 1'b0);
        for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i));
        idle(1);
        chk("mr_next_valid", codeword_valid, 1'b1);
        chk("mr_next_cw", codeWord, 72'hA8A7A6A5A4A3A2A1A0);
        idle(2);
        chk("mr_pulses", 72'(nv - nv0), 72'd1);
        chk("mr_no_err", 72'(ne - ne0), 72'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
